// File: rtl/maze_bfs_solver.sv
// BFS maze solver: serial maze in, goal->start path (or no-path verdict) out; one neighbour test per cycle.
// Latency N*N load beats + up to 5 cycles per dequeued cell; out beats held stable while out_ready is low.
module maze_bfs_solver #(
    parameter int N      = 15,
    parameter int QDEPTH = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic                   maze,
    output logic                   in_ready,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [$clog2(N)-1:0]   out_x,
    output logic [$clog2(N)-1:0]   out_y,
    output logic                   out_last,
    output logic                   maze_not_valid,
    output logic                   err_overflow
);
    localparam int CW        = $clog2(N);
    localparam int NN        = N * N;
    localparam int IW        = $clog2(NN);
    localparam int QW        = $clog2(QDEPTH);
    localparam int START_IDX = N + 1;
    localparam int GOAL_IDX  = (N - 2) * N + (N - 2);

    localparam logic [CW-1:0] C_ONE    = CW'(1);
    localparam logic [CW-1:0] C_GOAL   = CW'(N - 2);
    localparam logic [CW-1:0] C_LAST   = CW'(N - 1);
    localparam logic [IW-1:0] LAST_BIT = IW'(NN - 1);
    localparam logic [QW:0]   QFULL    = (QW + 1)'(QDEPTH);

    localparam logic [2:0] D_RIGHT = 3'd0;
    localparam logic [2:0] D_UP    = 3'd1;
    localparam logic [2:0] D_LEFT  = 3'd2;
    localparam logic [2:0] D_DOWN  = 3'd3;
    localparam logic [2:0] D_POP   = 3'd4;

    typedef enum logic [2:0] {S_LOAD, S_CHECK, S_SEARCH, S_BACK, S_DEAD} state_t;

    state_t             state_q, state_d;
    logic [IW-1:0]      bit_cnt_q, bit_cnt_d;
    logic [CW-1:0]      cur_x_q, cur_x_d, cur_y_q, cur_y_d;
    logic [2:0]         dir_q, dir_d;
    logic [QW-1:0]      head_q, head_d, tail_q, tail_d;
    logic [QW:0]        count_q, count_d;
    logic               out_valid_q, out_valid_d, out_last_q, out_last_d;
    logic               mnv_q, mnv_d, ovf_q, ovf_d;
    logic [CW-1:0]      out_x_q, out_x_d, out_y_q, out_y_d;

    logic [NN-1:0]      maze_q;
    logic [NN-1:0]      visited_q;
    logic [2*NN-1:0]    parent_q;
    logic [2*CW-1:0]    fifo_q [QDEPTH];

    logic               load_we, mark_start, nb_mark, push, clear_all;
    logic [CW-1:0]      nb_x, nb_y, step_x, step_y;
    logic [IW-1:0]      nb_idx, cur_idx;
    logic               nb_free;
    logic [1:0]         par_dir;

    // Neighbour under test for the current direction phase
    always_comb begin
        nb_x = cur_x_q;
        nb_y = cur_y_q;
        case (dir_q)
            D_RIGHT: nb_x = cur_x_q + C_ONE;
            D_UP:    nb_y = cur_y_q - C_ONE;
            D_LEFT:  nb_x = cur_x_q - C_ONE;
            D_DOWN:  nb_y = cur_y_q + C_ONE;
            default: ;
        endcase
    end

    assign nb_idx  = IW'(int'(nb_y) * N + int'(nb_x));
    assign cur_idx = IW'(int'(cur_y_q) * N + int'(cur_x_q));
    assign nb_free = !(nb_x == '0 || nb_x == C_LAST || nb_y == '0 || nb_y == C_LAST)
                     && !maze_q[nb_idx] && !visited_q[nb_idx];
    assign par_dir = parent_q[{cur_idx, 1'b0} +: 2];

    // Parent codes use the same direction numbering as the search phases
    always_comb begin
        step_x = cur_x_q;
        step_y = cur_y_q;
        case (par_dir)
            2'd0: step_x = cur_x_q + C_ONE;
            2'd1: step_y = cur_y_q - C_ONE;
            2'd2: step_x = cur_x_q - C_ONE;
            default: step_y = cur_y_q + C_ONE;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        cur_x_d     = cur_x_q;
        cur_y_d     = cur_y_q;
        dir_d       = dir_q;
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_x_d     = out_x_q;
        out_y_d     = out_y_q;
        mnv_d       = mnv_q;
        ovf_d       = ovf_q;
        load_we     = 1'b0;
        mark_start  = 1'b0;
        nb_mark     = 1'b0;
        push        = 1'b0;
        clear_all   = 1'b0;
        case (state_q)
            S_LOAD: begin
                if (in_valid) begin
                    load_we = 1'b1;
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = '0;
                        state_d   = S_CHECK;
                    end else begin
                        bit_cnt_d = bit_cnt_q + IW'(1);
                    end
                end
            end
            S_CHECK: begin
                if (maze_q[START_IDX] || maze_q[GOAL_IDX]) begin
                    state_d     = S_DEAD;
                    out_valid_d = 1'b1;
                    mnv_d       = 1'b1;
                    out_last_d  = 1'b1;
                    out_x_d     = '0;
                    out_y_d     = '0;
                end else begin
                    mark_start = 1'b1;
                    cur_x_d    = C_ONE;
                    cur_y_d    = C_ONE;
                    dir_d      = D_RIGHT;
                    state_d    = S_SEARCH;
                end
            end
            S_SEARCH: begin
                if (dir_q == D_POP) begin
                    if (count_q == '0) begin
                        state_d     = S_DEAD;
                        out_valid_d = 1'b1;
                        mnv_d       = 1'b1;
                        out_last_d  = 1'b1;
                        out_x_d     = '0;
                        out_y_d     = '0;
                    end else begin
                        cur_x_d = fifo_q[head_q][CW-1:0];
                        cur_y_d = fifo_q[head_q][2*CW-1:CW];
                        head_d  = head_q + QW'(1);
                        count_d = count_q - (QW + 1)'(1);
                        dir_d   = D_RIGHT;
                    end
                end else begin
                    dir_d = dir_q + 3'd1;
                    if (nb_free) begin
                        // Goal wins over a full queue: its parent is all the backtrack needs
                        if (nb_x == C_GOAL && nb_y == C_GOAL) begin
                            nb_mark     = 1'b1;
                            cur_x_d     = C_GOAL;
                            cur_y_d     = C_GOAL;
                            state_d     = S_BACK;
                            out_valid_d = 1'b1;
                            out_x_d     = C_GOAL;
                            out_y_d     = C_GOAL;
                            out_last_d  = 1'b0;
                            mnv_d       = 1'b0;
                        end else if (count_q == QFULL) begin
                            state_d     = S_DEAD;
                            ovf_d       = 1'b1;
                            out_valid_d = 1'b1;
                            mnv_d       = 1'b1;
                            out_last_d  = 1'b1;
                            out_x_d     = '0;
                            out_y_d     = '0;
                        end else begin
                            nb_mark = 1'b1;
                            push    = 1'b1;
                            tail_d  = tail_q + QW'(1);
                            count_d = count_q + (QW + 1)'(1);
                        end
                    end
                end
            end
            S_BACK, S_DEAD: begin
                if (out_ready) begin
                    if (state_q == S_DEAD || out_last_q) begin
                        state_d     = S_LOAD;
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        mnv_d       = 1'b0;
                        ovf_d       = 1'b0;
                        out_x_d     = '0;
                        out_y_d     = '0;
                        head_d      = '0;
                        tail_d      = '0;
                        count_d     = '0;
                        clear_all   = 1'b1;
                    end else begin
                        cur_x_d    = step_x;
                        cur_y_d    = step_y;
                        out_x_d    = step_x;
                        out_y_d    = step_y;
                        out_last_d = (step_x == C_ONE) && (step_y == C_ONE);
                    end
                end
            end
            default: state_d = S_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_LOAD;
            bit_cnt_q   <= '0;
            cur_x_q     <= '0;
            cur_y_q     <= '0;
            dir_q       <= D_RIGHT;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_x_q     <= '0;
            out_y_q     <= '0;
            mnv_q       <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            cur_x_q     <= cur_x_d;
            cur_y_q     <= cur_y_d;
            dir_q       <= dir_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_x_q     <= out_x_d;
            out_y_q     <= out_y_d;
            mnv_q       <= mnv_d;
            ovf_q       <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            maze_q    <= '0;
            visited_q <= '0;
            parent_q  <= '0;
            for (int i = 0; i < QDEPTH; i++) fifo_q[i] <= '0;
        end else begin
            if (load_we)    maze_q[bit_cnt_q] <= maze;
            if (clear_all)  visited_q <= '0;
            if (mark_start) visited_q[START_IDX] <= 1'b1;
            if (nb_mark) begin
                visited_q[nb_idx] <= 1'b1;
                parent_q[{nb_idx, 1'b0} +: 2] <= dir_q[1:0] + 2'd2;
            end
            if (push)       fifo_q[tail_q] <= {nb_y, nb_x};
        end
    end

    assign in_ready       = (state_q == S_LOAD);
    assign out_valid      = out_valid_q;
    assign out_x          = out_x_q;
    assign out_y          = out_y_q;
    assign out_last       = out_last_q;
    assign maze_not_valid = mnv_q;
    assign err_overflow   = ovf_q;
endmodule
